// File: rtl/counter_game_pkg.sv
// Shared constants for the game-counter session controller: FSM state codes,
// counter mode codes and round result codes.
package counter_game_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] ST_ARB   = 3'd2;
    localparam logic [ST_W-1:0] ST_LOAD  = 3'd3;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd4;
    localparam logic [ST_W-1:0] ST_SCORE = 3'd5;
    localparam logic [ST_W-1:0] ST_OVER  = 3'd6;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_TMO  = 2'b11;

    // True for the states that make up an active session (CLEAR..SCORE).
    function automatic logic in_session(input logic [ST_W-1:0] st);
        return (st >= ST_CLEAR) && (st <= ST_SCORE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IDX_W'((32'(ptr_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_game_sequencer.sv
// Session controller sharing one game counter between players in round-robin
// order; loads seed/mode per round, watches the counter flags, keeps scores.
module counter_game_sequencer
    import counter_game_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_PLAYERS-1:0]           p_req,
    input  logic [2*NUM_PLAYERS-1:0]         p_mode,
    input  logic [CNT_W*NUM_PLAYERS-1:0]     p_seed,
    output logic [NUM_PLAYERS-1:0]           p_gnt,
    output logic                             ctr_rst_n,
    output logic [1:0]                       ctr_ctrlBus,
    output logic [CNT_W-1:0]                 ctr_initValue,
    output logic                             ctr_INIT,
    input  logic                             ctr_WINNER,
    input  logic                             ctr_LOSER,
    input  logic                             ctr_GAMEOVER,
    output logic                             round_done,
    output logic [$clog2(NUM_PLAYERS)-1:0]   round_owner,
    output logic [1:0]                       round_result,
    output logic [SCORE_W*NUM_PLAYERS-1:0]   score,
    output logic                             busy,
    output logic                             session_over
);

    localparam int unsigned IDX_W = $clog2(NUM_PLAYERS);
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [ST_W-1:0]                state_q, state_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [IDX_W-1:0]               owner_q, owner_d;
    logic [1:0]                     mode_q, mode_d;
    logic [CNT_W-1:0]               seed_q, seed_d;
    logic [TMR_W-1:0]               timer_q, timer_d;
    logic [SCORE_W*NUM_PLAYERS-1:0] score_d;
    logic [IDX_W-1:0]               round_owner_d;
    logic [1:0]                     round_result_d;
    logic [SCORE_W-1:0]             cur_score;
    logic                           end_round;

    logic [NUM_PLAYERS-1:0]         p_gnt_d;
    logic                           ctr_rst_n_d;
    logic [1:0]                     ctr_ctrlBus_d;
    logic [CNT_W-1:0]               ctr_initValue_d;
    logic                           ctr_INIT_d;
    logic                           round_done_d;
    logic                           busy_d;
    logic                           session_over_d;
    logic                           load_d;

    logic [NUM_PLAYERS-1:0]         arb_gnt;
    logic [IDX_W-1:0]               arb_idx;
    logic                           arb_valid;

    rr_arbiter #(
        .N     (NUM_PLAYERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (p_req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        mode_d         = mode_q;
        seed_d         = seed_q;
        timer_d        = timer_q;
        score_d        = score;
        round_owner_d  = round_owner;
        round_result_d = round_result;
        end_round      = 1'b0;
        cur_score      = score[32'(owner_q)*SCORE_W +: SCORE_W];

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    score_d = '0;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: state_d = ST_ARB;
            ST_ARB: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    mode_d  = p_mode[32'(arb_idx)*2 +: 2];
                    seed_d  = p_seed[32'(arb_idx)*CNT_W +: CNT_W];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                timer_d = timer_q + TMR_W'(1);
                if (ctr_WINNER) begin
                    end_round      = 1'b1;
                    round_result_d = RES_WIN;
                    if (cur_score != SCORE_MAX) begin
                        score_d[32'(owner_q)*SCORE_W +: SCORE_W] = cur_score + SCORE_W'(1);
                    end
                end else if (ctr_LOSER) begin
                    end_round      = 1'b1;
                    round_result_d = RES_LOSE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    end_round      = 1'b1;
                    round_result_d = RES_TMO;
                end
                if (end_round) begin
                    state_d       = ST_SCORE;
                    round_owner_d = owner_q;
                    ptr_d         = (owner_q == IDX_W'(NUM_PLAYERS - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            ST_SCORE: state_d = ST_ARB;
            default:  state_d = ST_IDLE;
        endcase

        // Counter session over beats every other event and discards the round.
        if (ctr_GAMEOVER && in_session(state_q)) begin
            state_d        = ST_OVER;
            ptr_d          = ptr_q;
            score_d        = score;
            round_owner_d  = round_owner;
            round_result_d = round_result;
        end

        load_d          = (state_d == ST_LOAD);
        busy_d          = in_session(state_d);
        session_over_d  = (state_d == ST_OVER);
        ctr_rst_n_d     = in_session(state_d) && (state_d != ST_CLEAR);
        ctr_INIT_d      = load_d;
        p_gnt_d         = load_d ? arb_gnt : '0;
        ctr_initValue_d = load_d ? seed_d : '0;
        ctr_ctrlBus_d   = (load_d || (state_d == ST_RUN)) ? mode_d : '0;
        round_done_d    = (state_d == ST_SCORE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            mode_q        <= '0;
            seed_q        <= '0;
            timer_q       <= '0;
            score         <= '0;
            round_owner   <= '0;
            round_result  <= RES_NONE;
            p_gnt         <= '0;
            ctr_rst_n     <= 1'b0;
            ctr_ctrlBus   <= '0;
            ctr_initValue <= '0;
            ctr_INIT      <= 1'b0;
            round_done    <= 1'b0;
            busy          <= 1'b0;
            session_over  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            mode_q        <= mode_d;
            seed_q        <= seed_d;
            timer_q       <= timer_d;
            score         <= score_d;
            round_owner   <= round_owner_d;
            round_result  <= round_result_d;
            p_gnt         <= p_gnt_d;
            ctr_rst_n     <= ctr_rst_n_d;
            ctr_ctrlBus   <= ctr_ctrlBus_d;
            ctr_initValue <= ctr_initValue_d;
            ctr_INIT      <= ctr_INIT_d;
            round_done    <= round_done_d;
            busy          <= busy_d;
            session_over  <= session_over_d;
        end
    end

endmodule

// File: tb/tb_counter_game_sequencer.sv
// Directed bench for counter_game_sequencer: table of rounds plus hand-written
// sequences for saturation, GAMEOVER, start latency and mid-round reset.
module tb_counter_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] p_req;
    logic [3:0] p_mode;
    logic [7:0] p_seed;
    logic [1:0] p_gnt;
    logic       ctr_rst_n;
    logic [1:0] ctr_ctrlBus;
    logic [3:0] ctr_initValue;
    logic       ctr_INIT;
    logic       ctr_WINNER;
    logic       ctr_LOSER;
    logic       ctr_GAMEOVER;
    logic       round_done;
    logic [0:0] round_owner;
    logic [1:0] round_result;
    logic [7:0] score;
    logic       busy;
    logic       session_over;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    counter_game_sequencer #(
        .NUM_PLAYERS (2),
        .CNT_W       (4),
        .SCORE_W     (4),
        .TIMEOUT     (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .p_req         (p_req),
        .p_mode        (p_mode),
        .p_seed        (p_seed),
        .p_gnt         (p_gnt),
        .ctr_rst_n     (ctr_rst_n),
        .ctr_ctrlBus   (ctr_ctrlBus),
        .ctr_initValue (ctr_initValue),
        .ctr_INIT      (ctr_INIT),
        .ctr_WINNER    (ctr_WINNER),
        .ctr_LOSER     (ctr_LOSER),
        .ctr_GAMEOVER  (ctr_GAMEOVER),
        .round_done    (round_done),
        .round_owner   (round_owner),
        .round_result  (round_result),
        .score         (score),
        .busy          (busy),
        .session_over  (session_over)
    );

    // outcome: 0 = timeout (no flags), 1 = WINNER, 2 = LOSER, 3 = both
    typedef struct {
        logic [1:0] req;
        logic [3:0] mode;
        logic [7:0] seed;
        logic [1:0] outcome;
        logic [1:0] e_gnt;
        logic [1:0] e_mode;
        logic [3:0] e_init;
        logic       e_owner;
        logic [1:0] e_res;
        logic [7:0] e_score;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s/%s: actual %0h required %0h", tag, nm, act, exp);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, "ctr_rst_n", 32'(ctr_rst_n), 0);
        chk(tag, "ctrlBus", 32'(ctr_ctrlBus), 0);
        chk(tag, "initValue", 32'(ctr_initValue), 0);
        chk(tag, "INIT", 32'(ctr_INIT), 0);
        chk(tag, "p_gnt", 32'(p_gnt), 0);
        chk(tag, "round_done", 32'(round_done), 0);
        chk(tag, "owner", 32'(round_owner), 0);
        chk(tag, "result", 32'(round_result), 0);
        chk(tag, "score", 32'(score), 0);
        chk(tag, "busy", 32'(busy), 0);
        chk(tag, "session_over", 32'(session_over), 0);
    endtask

    task automatic wait_load(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (p_gnt != 2'b00) seen = 1'b1;
        end
        chk(tag, "load_seen", 32'(seen), 1);
    endtask

    task automatic run_round(input string tag, input vec_t v);
        int n;
        p_req  = v.req;
        p_mode = v.mode;
        p_seed = v.seed;
        wait_load(tag);
        chk(tag, "gnt", 32'(p_gnt), 32'(v.e_gnt));
        chk(tag, "INIT", 32'(ctr_INIT), 1);
        chk(tag, "initValue", 32'(ctr_initValue), 32'(v.e_init));
        chk(tag, "ctrlBus_load", 32'(ctr_ctrlBus), 32'(v.e_mode));
        ctr_WINNER = v.outcome[0];
        ctr_LOSER  = v.outcome[1];
        tick();
        chk(tag, "INIT_run", 32'(ctr_INIT), 0);
        chk(tag, "ctrlBus_run", 32'(ctr_ctrlBus), 32'(v.e_mode));
        n = 1;
        while (!round_done && n < 40) begin
            tick();
            n++;
        end
        chk(tag, "round_done", 32'(round_done), 1);
        chk(tag, "run_cycles", 32'(n - 1), (v.outcome == 2'd0) ? 32 : 1);
        chk(tag, "owner", 32'(round_owner), 32'(v.e_owner));
        chk(tag, "result", 32'(round_result), 32'(v.e_res));
        chk(tag, "score", 32'(score), 32'(v.e_score));
        ctr_WINNER = 1'b0;
        ctr_LOSER  = 1'b0;
    endtask

    initial begin
        vec_t v;
        bit   seen_done;
        bit   seen_gnt;

        //          req    mode     seed   out    gnt    mode   init  own  res    score
        vecs[0] = '{2'b01, 4'b0000, 8'h0E, 2'd1, 2'b01, 2'b00, 4'hE, 1'b0, 2'b01, 8'h01};
        vecs[1] = '{2'b11, 4'b0100, 8'h3E, 2'd1, 2'b10, 2'b01, 4'h3, 1'b1, 2'b01, 8'h11};
        vecs[2] = '{2'b11, 4'b0110, 8'h35, 2'd2, 2'b01, 2'b10, 4'h5, 1'b0, 2'b10, 8'h11};
        vecs[3] = '{2'b11, 4'b0110, 8'h75, 2'd1, 2'b10, 2'b01, 4'h7, 1'b1, 2'b01, 8'h21};
        vecs[4] = '{2'b11, 4'b0011, 8'h72, 2'd3, 2'b01, 2'b11, 4'h2, 1'b0, 2'b01, 8'h22};
        vecs[5] = '{2'b01, 4'b0011, 8'h01, 2'd2, 2'b01, 2'b11, 4'h1, 1'b0, 2'b10, 8'h22};
        vecs[6] = '{2'b10, 4'b1000, 8'h90, 2'd0, 2'b10, 2'b10, 4'h9, 1'b1, 2'b11, 8'h22};

        rst_n = 1'b0; start = 1'b0; p_req = '0; p_mode = '0; p_seed = '0;
        ctr_WINNER = 1'b0; ctr_LOSER = 1'b0; ctr_GAMEOVER = 1'b0;
        tick();
        tick();
        check_reset_outs("reset");
        rst_n = 1'b1;
        tick();
        chk("idle", "busy", 32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear", "busy", 32'(busy), 1);
        chk("clear", "ctr_rst_n", 32'(ctr_rst_n), 0);

        for (int i = 0; i < 7; i++) run_round($sformatf("vec%0d", i), vecs[i]);

        // Player 1 wins 16 more rounds; score 2 saturates at F.
        for (int i = 0; i < 16; i++) begin
            v = '{2'b10, 4'b0000, 8'hF0, 2'd1, 2'b10, 2'b00, 4'hF, 1'b1, 2'b01, 8'h02};
            v.e_score[7:4] = (i >= 12) ? 4'hF : 4'(3 + i);
            run_round($sformatf("sat%0d", i), v);
        end

        // GAMEOVER mid-RUN: straight to OVER, no round pulse, scores held.
        p_req = 2'b01;
        wait_load("gover");
        tick();
        ctr_GAMEOVER = 1'b1;
        tick();
        ctr_GAMEOVER = 1'b0;
        chk("gover", "session_over", 32'(session_over), 1);
        chk("gover", "busy", 32'(busy), 0);
        chk("gover", "ctr_rst_n", 32'(ctr_rst_n), 0);
        chk("gover", "ctrlBus", 32'(ctr_ctrlBus), 0);
        chk("gover", "score", 32'(score), 32'h F2);
        seen_done = 1'b0;
        seen_gnt  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_done |= round_done;
            seen_gnt  |= (p_gnt != 2'b00);
            tick();
        end
        chk("gover", "no_round_done", 32'(seen_done), 0);
        chk("gover", "no_grant", 32'(seen_gnt), 0);
        chk("gover", "still_over", 32'(session_over), 1);

        // Restart from OVER: scores clear, LOAD two edges after start.
        p_req = 2'b10;
        p_mode = 4'b1100;
        p_seed = 8'hA0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart", "score", 32'(score), 0);
        chk("restart", "busy", 32'(busy), 1);
        chk("restart", "session_over", 32'(session_over), 0);
        tick();
        chk("restart", "gnt_arb", 32'(p_gnt), 0);
        tick();
        chk("restart", "gnt_load", 32'(p_gnt), 32'h2);
        chk("restart", "initValue", 32'(ctr_initValue), 32'hA);
        ctr_WINNER = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ctr_WINNER = 1'b0;
        chk("restart", "round_done", 32'(round_done), 1);
        chk("restart", "owner", 32'(round_owner), 1);
        chk("restart", "result", 32'(round_result), 32'h1);
        chk("restart", "score_after", 32'(score), 32'h10);

        // Reset in the middle of a round: everything back to reset values.
        wait_load("midrst");
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_outs("midrst");
        rst_n = 1'b1;
        seen_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_gnt |= (p_gnt != 2'b00) | busy;
        end
        chk("idle_after_rst", "no_activity", 32'(seen_gnt), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
